tl_slave_mem_q: RTL and testbench
=================================

// Module: tl_slave_mem_q
// PURPOSE
//  Parametrised successor of the single-transaction master/slave memory slave.
//  Accepts packed A-channel requests (Get/PutFull/PutPartial), services them from
//  a word-addressed internal memory and returns D-channel responses.
//  Responses pass through an RSP_DEPTH-entry queue, so several transactions are
//  outstanding, each tagged by source ID. Sits between the pipeline memory-stage
//  master and data memory.
// PARAMETERS
//  ADDR_W     32   byte address width
//  DATA_W     32   data width; multiple of 8, >=16
//  SRC_W      2    source-ID width, echoed unchanged on D
//  MEM_DEPTH  256  memory depth in DATA_W words
//  RSP_DEPTH  4    response queue entries; power of 2, >=2
// PORTS
//  clk                in   1                 rising-edge clock
//  reset              in   1                 async active-high reset
//  a_valid            in   1                 A request valid
//  a_ready            out  1                 A request accepted when a_valid&&a_ready
//  a_channel          in   3+SRC_W+ADDR_W+DATA_W+DATA_W/8  {opcode,source,addr,data,mask}, MSB first (73 at defaults)
//  d_valid            out  1                 D response valid
//  d_ready            in   1                 master consumes D when d_valid&&d_ready
//  d_channel          out  3+SRC_W+DATA_W    {opcode,source,data}, MSB first (37 at defaults)
//  d_error            out  1                 error flag of current D response
//  backpressureslave  out  1                 queue at high-water mark (count>=RSP_DEPTH-1)
//  stat_rd/stat_wr/stat_err  out  16 each    counters (see CONFIGURATION)
// BEHAVIOUR
//  - Reset, async, active-high: queue empty, count=0, d_valid=0, d_channel=0, d_error=0,
//    backpressureslave=0, a_ready=0 while reset is high. Memory is not reset.
//  - a_ready = !reset && count<RSP_DEPTH. No full-queue bypass: when full, a_ready=0
//    even if the same cycle pops.
//  - A opcodes: 0 PutFullData (all bytes written, mask ignored); 1 PutPartialData
//    (byte i written iff mask[i]); 4 Get. Index = addr>>log2(DATA_W/8).
//  - Error if any of: opcode not in {0,1,4}; addr low bits nonzero (misaligned);
//    index>=MEM_DEPTH. Errored requests write nothing and return data=0, d_error=1.
//    Bad opcode returns AccessAck.
//  - Response: Get -> AccessAckData (opcode 1), data = memory word before any same-edge
//    write. Put -> AccessAck (opcode 0), data 0. Source is echoed unchanged.
//  - Latency: write commits and response enqueues on the accepting edge. d_valid is
//    visible the next cycle at the earliest (1-cycle latency when the queue is empty).
//  - Queue is strict FIFO; responses leave in acceptance order. The d_channel/d_error
//    head is stable while d_valid&&!d_ready.
//  - Push and pop on the same edge: count unchanged. Pointers wrap modulo RSP_DEPTH.
//  - Read-after-write to the same word in consecutive accepted requests returns the
//    new data.
//  - Reset mid-operation discards queued responses. No D response is issued for them
//    after reset.
// CONFIGURATION
//  - TL_SLAVE_STATS_EN defined: stat_rd counts accepted Gets, stat_wr counts accepted
//    Puts without error, stat_err counts errored requests. Counters are 16-bit,
//    saturate at 16'hFFFF and clear on reset.
//  - Undefined: stat_* are tied to 16'h0 and no counter registers exist. All other
//    behaviour is identical.
// TESTING
//  1 Reset, PutFull src=1 addr=0x10 data=0xDEADBEEF, then Get src=2 addr=0x10
//    -> D: {0,1,0,err0} then {1,2,0xDEADBEEF,err0}.
//  2 PutPartial addr=0x10 data=0x00001122 mask=4'b0011 over 0xDEADBEEF, then Get
//    -> 0xDEAD1122.
//  3 Hold d_ready=0 and issue 4 Gets: backpressureslave=1 after 3rd accept, a_ready=0
//    after 4th. 5th held off. Raise d_ready -> responses in order; 5th accepted once count<4.
//  4 Get addr=0x402 (misaligned), Get addr=0x400 (index 256), opcode 7
//    -> three responses, d_error=1, data=0, memory unchanged.
//  5 Queue 2 entries, assert reset mid-burst -> d_valid=0 immediately. After release,
//    no stale response; a_ready=1.
//  6 With TL_SLAVE_STATS_EN: 3 Gets, 2 Puts, 1 error -> stat_rd=3, stat_wr=2, stat_err=1.
//    Without it: all stat_* read 0.

Source files
------------

// File: rtl/tl_slave_mem_q.sv
// TileLink-style memory slave: A-channel Get/PutFull/PutPartial served from a word memory,
// D-channel responses returned through an RSP_DEPTH FIFO. Optional counters under TL_SLAVE_STATS_EN.
module tl_slave_mem_q #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SRC_W     = 2,
   parameter int MEM_DEPTH = 256,
   parameter int RSP_DEPTH = 4
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         a_valid,
   output logic                                         a_ready,
   input  logic [3+SRC_W+ADDR_W+DATA_W+DATA_W/8-1:0]    a_channel,
   output logic                                         d_valid,
   input  logic                                         d_ready,
   output logic [3+SRC_W+DATA_W-1:0]                    d_channel,
   output logic                                         d_error,
   output logic                                         backpressureslave,
   output logic [15:0]                                  stat_rd,
   output logic [15:0]                                  stat_wr,
   output logic [15:0]                                  stat_err
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int MIDX_W = $clog2(MEM_DEPTH);
   localparam int PTR_W  = $clog2(RSP_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [2:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_GET         = 3'd4
   } a_op_e;

   typedef enum logic [2:0] {
      D_ACK      = 3'd0,
      D_ACK_DATA = 3'd1
   } d_op_e;

   typedef struct packed {
      logic [2:0]        op;
      logic [SRC_W-1:0]  src;
      logic [DATA_W-1:0] data;
      logic              err;
   } rsp_t;

   // A-channel fields
   logic [2:0]        w_a_op;
   logic [SRC_W-1:0]  w_a_src;
   logic [ADDR_W-1:0] w_a_addr;
   logic [DATA_W-1:0] w_a_data;
   logic [STRB_W-1:0] w_a_mask;

   assign {w_a_op, w_a_src, w_a_addr, w_a_data, w_a_mask} = a_channel;

   logic [ADDR_W-1:0] w_index;
   logic [MIDX_W-1:0] w_mem_idx;
   logic              w_is_get;
   logic              w_is_put;
   logic              w_misaligned;
   logic              w_out_of_range;
   logic              w_err;
   logic              w_push;
   logic              w_pop;
   logic              w_wr_en;
   logic [STRB_W-1:0] w_byte_en;
   logic [DATA_W-1:0] w_rd_word;
   rsp_t              w_rsp;
   rsp_t              w_head;

   assign w_index        = w_a_addr >> OFF_W;
   assign w_mem_idx      = w_index[MIDX_W-1:0];
   assign w_is_get       = (w_a_op == A_GET);
   assign w_is_put       = (w_a_op == A_PUT_FULL) || (w_a_op == A_PUT_PARTIAL);
   assign w_misaligned   = |w_a_addr[OFF_W-1:0];
   assign w_out_of_range = (w_index >= ADDR_W'(MEM_DEPTH));
   assign w_err          = !(w_is_get || w_is_put) || w_misaligned || w_out_of_range;

   // Queue state and handshakes
   rsp_t              r_q [RSP_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   // Full queue never accepts, even when the head pops on the same edge.
   assign a_ready           = !reset && (r_count < CNT_W'(RSP_DEPTH));
   assign d_valid           = (r_count != '0);
   assign backpressureslave = (r_count >= CNT_W'(RSP_DEPTH - 1));
   assign w_push            = a_valid && a_ready;
   assign w_pop             = d_valid && d_ready;

   assign w_wr_en = w_push && w_is_put && !w_err;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_byte_en = '0;
      for (int i = 0; i < STRB_W; i++) begin
         w_byte_en[i] = w_wr_en && ((w_a_op == A_PUT_FULL) || w_a_mask[i]);
      end
   end

   // Data memory
   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   // NOTE: storage arrays carry no reset; their contents are only meaningful once written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_W; i++) begin
         if (w_byte_en[i]) begin
            r_mem[w_mem_idx][8*i +: 8] <= w_a_data[8*i +: 8];
         end
      end
   end

   // Get returns the word as it was before this edge's write.
   assign w_rd_word = r_mem[w_mem_idx];

   always_comb begin
      w_rsp      = '0;
      w_rsp.op   = w_is_get ? D_ACK_DATA : D_ACK;
      w_rsp.src  = w_a_src;
      w_rsp.err  = w_err;
      if (w_is_get && !w_err) begin
         w_rsp.data = w_rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q[r_wr_ptr] <= w_rsp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Outputs are forced to zero whenever nothing is queued (including during reset).
   assign w_head    = r_q[r_rd_ptr];
   assign d_channel = d_valid ? {w_head.op, w_head.src, w_head.data} : '0;
   assign d_error   = d_valid && w_head.err;

`ifdef TL_SLAVE_STATS_EN
   logic [15:0] r_stat_rd;
   logic [15:0] r_stat_wr;
   logic [15:0] r_stat_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stat_rd  <= '0;
         r_stat_wr  <= '0;
         r_stat_err <= '0;
      end else begin
         if (w_push && w_is_get && (r_stat_rd != 16'hFFFF)) begin
            r_stat_rd <= r_stat_rd + 16'd1;
         end
         if (w_wr_en && (r_stat_wr != 16'hFFFF)) begin
            r_stat_wr <= r_stat_wr + 16'd1;
         end
         if (w_push && w_err && (r_stat_err != 16'hFFFF)) begin
            r_stat_err <= r_stat_err + 16'd1;
         end
      end
   end

   assign stat_rd  = r_stat_rd;
   assign stat_wr  = r_stat_wr;
   assign stat_err = r_stat_err;
`else
   assign stat_rd  = 16'h0;
   assign stat_wr  = 16'h0;
   assign stat_err = 16'h0;
`endif

endmodule

// File: tb/tb_tl_slave_mem_q.sv
// Bench for tl_slave_mem_q: directed vector table, backpressure/reset sequences, and a random
// phase, all cross-checked every cycle by a queue-based reference model.
module tb_tl_slave_mem_q;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int SRC_W     = 2;
   localparam int MEM_DEPTH = 256;
   localparam int RSP_DEPTH = 4;
   localparam int A_W       = 3 + SRC_W + ADDR_W + DATA_W + DATA_W/8;
   localparam int D_W       = 3 + SRC_W + DATA_W;

   logic             clk;
   logic             reset;
   logic             a_valid;
   logic             a_ready;
   logic [A_W-1:0]   a_channel;
   logic             d_valid;
   logic             d_ready;
   logic [D_W-1:0]   d_channel;
   logic             d_error;
   logic             backpressureslave;
   logic [15:0]      stat_rd;
   logic [15:0]      stat_wr;
   logic [15:0]      stat_err;

   int total = 0;
   int bad   = 0;

   tl_slave_mem_q #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W),
      .MEM_DEPTH(MEM_DEPTH), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_channel(a_channel),
      .d_valid(d_valid), .d_ready(d_ready), .d_channel(d_channel), .d_error(d_error),
      .backpressureslave(backpressureslave),
      .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [A_W-1:0] pack_a(input logic [2:0] op, input logic [SRC_W-1:0] src,
                                             input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] mask);
      return {op, src, addr, data, mask};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (evaluated on the falling edge) ----------------
   typedef struct {
      logic [2:0]       op;
      logic [SRC_W-1:0] src;
      logic [31:0]      data;
      logic             err;
      bit               known;
   } m_rsp_t;

   m_rsp_t      mq[$];
   logic [31:0] mmem[MEM_DEPTH];
   bit          mknown[MEM_DEPTH];
   int          m_rd = 0;
   int          m_wr = 0;
   int          m_err = 0;

   always @(negedge clk) begin
      logic [2:0]  op;
      logic [1:0]  src;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      longint      idx;
      bit          err;
      bit          exp_ready;
      m_rsp_t      r;
      m_rsp_t      h;
      if (reset) begin
         check("rst_a_ready", a_ready, 0);
         check("rst_d_valid", d_valid, 0);
         check("rst_d_channel", d_channel, 0);
         check("rst_d_error", d_error, 0);
         check("rst_bp", backpressureslave, 0);
         mq.delete();
         m_rd = 0; m_wr = 0; m_err = 0;
      end else begin
         exp_ready = (mq.size() < RSP_DEPTH);
         check("a_ready", a_ready, exp_ready);
         check("d_valid", d_valid, mq.size() != 0);
         check("backpressure", backpressureslave, mq.size() >= RSP_DEPTH - 1);
         if (mq.size() != 0) begin
            h = mq[0];
            check("d_opcode", d_channel[D_W-1 -: 3], h.op);
            check("d_source", d_channel[DATA_W +: SRC_W], h.src);
            check("d_error", d_error, h.err);
            if (h.known) check("d_data", d_channel[DATA_W-1:0], h.data);
         end
`ifdef TL_SLAVE_STATS_EN
         check("stat_rd", stat_rd, m_rd);
         check("stat_wr", stat_wr, m_wr);
         check("stat_err", stat_err, m_err);
`else
         check("stat_zero", {stat_rd, stat_wr, stat_err}, 0);
`endif
         // Predict the coming rising edge.
         if (d_ready && mq.size() != 0) void'(mq.pop_front());
         if (a_valid && exp_ready) begin
            {op, src, addr, data, mask} = a_channel;
            idx = longint'(addr) / 4;
            err = !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (addr % 4 != 0) || (idx >= MEM_DEPTH);
            r.op = (op == 3'd4) ? 3'd1 : 3'd0;
            r.src = src;
            r.err = err;
            r.data = 32'h0;
            r.known = 1'b1;
            if (op == 3'd4 && m_rd < 65535) m_rd++;
            if (err) begin
               if (m_err < 65535) m_err++;
            end else if (op == 3'd4) begin
               r.data = mmem[idx];
               r.known = mknown[idx];
            end else begin
               if (m_wr < 65535) m_wr++;
               for (int b = 0; b < 4; b++)
                  if (op == 3'd0 || mask[b]) mmem[idx][8*b +: 8] = data[8*b +: 8];
               if (op == 3'd0) mknown[idx] = 1'b1;
            end
            mq.push_back(r);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [2:0] op, input logic [SRC_W-1:0] src, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask);
      int n;
      a_channel = pack_a(op, src, addr, data, mask);
      a_valid   = 1'b1;
      n = 0;
      while (!a_ready && n < 50) begin
         cycle();
         n++;
      end
      check("accept_within_budget", a_ready, 1);
      cycle();
      a_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  src;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [2:0]  exp_op;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[18];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{3'd0, 2'd0, 32'h000, 32'h0BADF00D, 4'hF, 3'd0, 32'h0,        1'b0};
      vecs[1]  = '{3'd0, 2'd1, 32'h010, 32'hDEADBEEF, 4'h0, 3'd0, 32'h0,        1'b0};
      vecs[2]  = '{3'd4, 2'd2, 32'h010, 32'h0,        4'h0, 3'd1, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{3'd1, 2'd3, 32'h010, 32'h00001122, 4'h3, 3'd0, 32'h0,        1'b0};
      vecs[4]  = '{3'd4, 2'd0, 32'h010, 32'h0,        4'h0, 3'd1, 32'hDEAD1122, 1'b0};
      vecs[5]  = '{3'd1, 2'd1, 32'h010, 32'hAABBCCDD, 4'h8, 3'd0, 32'h0,        1'b0};
      vecs[6]  = '{3'd4, 2'd2, 32'h010, 32'h0,        4'h0, 3'd1, 32'hAAAD1122, 1'b0};
      vecs[7]  = '{3'd0, 2'd3, 32'h3FC, 32'h12345678, 4'hF, 3'd0, 32'h0,        1'b0};
      vecs[8]  = '{3'd4, 2'd1, 32'h3FC, 32'h0,        4'h0, 3'd1, 32'h12345678, 1'b0};
      vecs[9]  = '{3'd4, 2'd2, 32'h402, 32'h0,        4'h0, 3'd1, 32'h0,        1'b1};
      vecs[10] = '{3'd4, 2'd3, 32'h400, 32'h0,        4'h0, 3'd1, 32'h0,        1'b1};
      vecs[11] = '{3'd7, 2'd0, 32'h010, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0,        1'b1};
      vecs[12] = '{3'd0, 2'd1, 32'h3FE, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0,        1'b1};
      vecs[13] = '{3'd0, 2'd2, 32'h400, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0,        1'b1};
      vecs[14] = '{3'd4, 2'd3, 32'h010, 32'h0,        4'h0, 3'd1, 32'hAAAD1122, 1'b0};
      vecs[15] = '{3'd4, 2'd0, 32'h3FC, 32'h0,        4'h0, 3'd1, 32'h12345678, 1'b0};
      vecs[16] = '{3'd4, 2'd1, 32'h000, 32'h0,        4'h0, 3'd1, 32'h0BADF00D, 1'b0};
      vecs[17] = '{3'd5, 2'd2, 32'h3FC, 32'h0,        4'h0, 3'd0, 32'h0,        1'b1};

      reset = 1'b1; a_valid = 1'b0; d_ready = 1'b0; a_channel = '0;
      repeat (3) cycle();
      check("reset_a_ready_low", a_ready, 0);
      reset = 1'b0;
      #1;
      check("post_reset_a_ready", a_ready, 1);
      check("post_reset_d_valid", d_valid, 0);

      // Directed vector table, one transaction at a time.
      for (int i = 0; i < 18; i++) begin
         check($sformatf("vec%0d_idle", i), d_valid, 0);
         send(vecs[i].op, vecs[i].src, vecs[i].addr, vecs[i].data, vecs[i].mask);
         check($sformatf("vec%0d_latency", i), d_valid, 1);
         check($sformatf("vec%0d_d_channel", i), d_channel,
               {vecs[i].exp_op, vecs[i].src, vecs[i].exp_data});
         check($sformatf("vec%0d_d_error", i), d_error, vecs[i].exp_err);
         d_ready = 1'b1;
         cycle();
         d_ready = 1'b0;
      end

      // Backpressure: fill the queue with d_ready low.
      for (int k = 0; k < 4; k++) begin
         a_channel = pack_a(3'd4, 2'(k), 32'h010, 32'h0, 4'h0);
         a_valid   = 1'b1;
         check($sformatf("bp_ready_before_%0d", k), a_ready, 1);
         cycle();
         check($sformatf("bp_flag_after_%0d", k), backpressureslave, k >= 2);
         check($sformatf("bp_a_ready_after_%0d", k), a_ready, k < 3);
      end
      a_channel = pack_a(3'd4, 2'd1, 32'h3FC, 32'h0, 4'h0);
      repeat (3) begin
         cycle();
         check("bp_fifth_held", a_ready, 0);
         check("bp_head_stable", d_channel, {3'd1, 2'd0, 32'hAAAD1122});
      end
      d_ready = 1'b1;
      #1;
      check("bp_no_full_bypass", a_ready, 0);
      cycle();
      check("bp_ready_after_pop", a_ready, 1);
      cycle();
      a_valid = 1'b0;
      check("bp_count3_flag", backpressureslave, 1);
      check("bp_order_2", d_channel, {3'd1, 2'd2, 32'hAAAD1122});
      cycle();
      check("bp_order_3", d_channel, {3'd1, 2'd3, 32'hAAAD1122});
      cycle();
      check("bp_order_5th", d_channel, {3'd1, 2'd1, 32'h12345678});
      cycle();
      check("bp_drained", d_valid, 0);
      d_ready = 1'b0;

      // Reset with two responses queued.
      send(3'd0, 2'd3, 32'h020, 32'hCAFEF00D, 4'hF);
      send(3'd4, 2'd2, 32'h020, 32'h0, 4'h0);
      check("rstq_two_pending", d_valid, 1);
      reset = 1'b1;
      #1;
      check("rstq_d_valid_immediate", d_valid, 0);
      check("rstq_d_channel_zero", d_channel, 0);
      cycle();
      cycle();
      reset = 1'b0;
      d_ready = 1'b1;
      #1;
      check("rstq_a_ready_after", a_ready, 1);
      repeat (4) begin
         cycle();
         check("rstq_no_stale", d_valid, 0);
      end

      // Counter scenario right after reset: 3 Gets, 2 Puts, 1 error.
      send(3'd4, 2'd0, 32'h010, 32'h0, 4'h0);
      send(3'd0, 2'd1, 32'h040, 32'h11112222, 4'hF);
      send(3'd4, 2'd2, 32'h000, 32'h0, 4'h0);
      send(3'd1, 2'd3, 32'h040, 32'h0000FFFF, 4'h1);
      send(3'd7, 2'd0, 32'h010, 32'h0, 4'h0);
      send(3'd4, 2'd1, 32'h3FC, 32'h0, 4'h0);
      repeat (3) cycle();
`ifdef TL_SLAVE_STATS_EN
      check("stats_rd", stat_rd, 16'd3);
      check("stats_wr", stat_wr, 16'd2);
      check("stats_err", stat_err, 16'd1);
`else
      check("stats_rd_tied", stat_rd, 16'd0);
      check("stats_wr_tied", stat_wr, 16'd0);
      check("stats_err_tied", stat_err, 16'd0);
`endif

      // Random phase over a prefilled window of 16 words.
      for (int w = 0; w < 16; w++) send(3'd0, 2'(w), 32'(w * 4), $urandom, 4'hF);
      repeat (2) cycle();
      for (int n = 0; n < 800; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         int          sel;
         sel = $urandom_range(0, 9);
         if (sel < 3)      op = 3'd0;
         else if (sel < 5) op = 3'd1;
         else if (sel < 9) op = 3'd4;
         else              op = 3'($urandom_range(5, 7));
         sel = $urandom_range(0, 19);
         if (sel < 18)       addr = 32'($urandom_range(0, 15) * 4);
         else if (sel == 18) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else                addr = 32'h400 + 32'($urandom_range(0, 15) * 4);
         a_channel = pack_a(op, 2'($urandom_range(0, 3)), addr, $urandom, 4'($urandom_range(0, 15)));
         a_valid   = ($urandom_range(0, 9) < 7);
         d_ready   = ($urandom_range(0, 9) < 6);
         cycle();
      end
      a_valid = 1'b0;
      d_ready = 1'b1;
      repeat (8) cycle();
      check("random_drained", d_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
